// File: rtl/host_cmd_pkg.sv
// Shared types and constants for the host command controller.
package host_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CHK,
    EXEC,
    ACK
  } state_t;

  localparam logic [7:0] ADDR_TW   = 8'h01;
  localparam logic [7:0] ADDR_MODE = 8'h02;
  localparam logic [7:0] ADDR_CHEN = 8'h03;
  localparam logic [7:0] ADDR_CTRL = 8'h04;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_BUSY = 8'h16;

  function automatic logic [7:0] frame_xor(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

endpackage

// File: rtl/host_cmd_frame_rx.sv
// Frame parser: header detect, byte assembly, checksum compare, inter-byte timeout.
// Owns the frame FSM; holds in EXEC/ACK until the top completes the response handshake.
module host_cmd_frame_rx
  import host_cmd_pkg::*;
#(
  parameter logic [7:0]  CMD_HEADER     = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        ack_done,
  output logic        frame_valid,
  output logic        chk_ok,
  output logic [7:0]  addr,
  output logic [31:0] data,
  output logic        timeout
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [7:0]    chk_r;
  logic [TW-1:0] to_cnt;
  logic          parsing;

  assign parsing     = (state == ADDR) || (state == DATA) || (state == CHK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout     = parsing && !rx_done && (to_cnt == TO_LAST);
  assign frame_valid = (state == EXEC);
  assign chk_ok      = (frame_xor(addr, data) == chk_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_done && rx_data == CMD_HEADER) state_nxt = ADDR;
      ADDR: begin
        if (timeout)      state_nxt = IDLE;
        else if (rx_done) state_nxt = DATA;
      end
      DATA: begin
        if (timeout)                         state_nxt = IDLE;
        else if (rx_done && byte_cnt == 2'd3) state_nxt = CHK;
      end
      CHK: begin
        if (timeout)      state_nxt = IDLE;
        else if (rx_done) state_nxt = EXEC;
      end
      EXEC: state_nxt = ACK;
      ACK:  if (ack_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      addr     <= '0;
      data     <= '0;
      chk_r    <= '0;
      to_cnt   <= '0;
    end else begin
      if (rx_done || !parsing) to_cnt <= '0;
      else                     to_cnt <= to_cnt + 1'b1;

      if (state != DATA) byte_cnt <= '0;
      else if (rx_done)  byte_cnt <= byte_cnt + 2'd1;

      if (rx_done) begin
        case (state)
          ADDR: addr <= rx_data;
          DATA: begin
            case (byte_cnt)
              2'd0:    data[7:0]   <= rx_data;
              2'd1:    data[15:8]  <= rx_data;
              2'd2:    data[23:16] <= rx_data;
              default: data[31:24] <= rx_data;
            endcase
          end
          CHK:     chk_r <= rx_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/host_cmd_ctrl.sv
// Host command controller: executes parsed frames into core configuration
// registers and returns a one-byte ACK/NAK over a valid/ready handshake.
module host_cmd_ctrl
  import host_cmd_pkg::*;
#(
  parameter int unsigned CHAN_NUM       = 32,
  parameter logic [7:0]  CMD_HEADER     = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter logic [7:0]  TW_DEFAULT     = 8'd10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic [7:0]          timing_window,
  output logic [1:0]          test_mode,
  output logic [CHAN_NUM-1:0] chan_enable,
  output logic                run,
  output logic                soft_rst,
  output logic [7:0]          ack_data,
  output logic                ack_valid,
  input  logic                ack_ready,
  output logic [7:0]          err_count
);

  logic        frame_valid;
  logic        chk_ok;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        timeout;
  logic        ack_done;
  logic [7:0]  rsp;
  logic        accept;
  logic        err_inc;

  assign ack_done = ack_valid && ack_ready;

  host_cmd_frame_rx #(
    .CMD_HEADER     (CMD_HEADER),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .ack_done    (ack_done),
    .frame_valid (frame_valid),
    .chk_ok      (chk_ok),
    .addr        (addr),
    .data        (data),
    .timeout     (timeout)
  );

  always_comb begin
    rsp = RSP_ACK;
    if (!chk_ok)
      rsp = RSP_NAK;
    else if (!(addr inside {ADDR_TW, ADDR_MODE, ADDR_CHEN, ADDR_CTRL}))
      rsp = RSP_NAK;
    else if (addr == ADDR_MODE && data[1:0] == 2'b11)
      rsp = RSP_NAK;
    else if (addr != ADDR_CTRL && run)
      rsp = RSP_BUSY;
  end

  assign accept  = (rsp == RSP_ACK);
  assign err_inc = (frame_valid && !accept) || timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timing_window <= TW_DEFAULT;
      test_mode     <= '0;
      chan_enable   <= '1;
      run           <= 1'b0;
      soft_rst      <= 1'b0;
      ack_data      <= '0;
      ack_valid     <= 1'b0;
      err_count     <= '0;
    end else begin
      soft_rst <= 1'b0;
      if (ack_done) ack_valid <= 1'b0;

      if (frame_valid) begin
        ack_data  <= rsp;
        ack_valid <= 1'b1;
        if (accept) begin
          case (addr)
            ADDR_TW:   timing_window <= data[7:0];
            ADDR_MODE: test_mode     <= data[1:0];
            ADDR_CHEN: chan_enable   <= data[CHAN_NUM-1:0];
            ADDR_CTRL: begin
              run      <= data[0];
              soft_rst <= data[1];
            end
            default: ;
          endcase
        end
      end

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/host_cmd_ctrl.md
Name: host_cmd_ctrl

Overview:
Framed host-command controller between the UART receiver and the coincidence core. It parses fixed-length command frames, validates them with an XOR checksum, and updates the core configuration: timing window, test mode, per-channel enable mask, and run/soft-reset. Every completed frame returns a one-byte ACK/NAK to the UART transmit path through a valid/ready handshake. An inter-byte timeout resynchronises the parser.

Parameters:
CHAN_NUM, 32, number of detector channels; width of chan_enable (max 32).
CMD_HEADER, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 200_000, inter-byte timeout in clk cycles (1 ms at 200 MHz).
TW_DEFAULT, 8'd10, reset value of timing_window.

Ports:
clk  in  1  system clock (200 MHz domain)
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte from uart_rx
rx_done  in  1  one-cycle strobe; rx_data valid
timing_window  out  8  coincidence window to core
test_mode  out  2  core test mode (00 normal, 01, 10)
chan_enable  out  CHAN_NUM  per-channel enable mask
run  out  1  acquisition enable
soft_rst  out  1  one-cycle pulse to reset core datapath
ack_data  out  8  response byte
ack_valid  out  1  response valid; held until ack_ready
ack_ready  in  1  TX path accepts ack_data
err_count  out  8  saturating count of NAKs and timeouts

Behaviour:
- Reset values: timing_window=TW_DEFAULT, test_mode=00, chan_enable=all ones, run=0, soft_rst=0, ack_data=00, ack_valid=0, err_count=0, state=IDLE.
- Frame layout is 7 bytes: HEADER, ADDR, D0, D1, D2, D3, CHK. CHK = ADDR^D0^D1^D2^D3.
- States:
  - IDLE: on rx_done with byte==CMD_HEADER go to ADDR; other bytes are dropped silently.
  - ADDR: latch addr, go to DATA.
  - DATA: 2-bit byte counter 0..3 stores D0..D3; after D3 go to CHK.
  - CHK: latch chk, go to EXEC.
  - EXEC: one cycle, then ACK.
  - ACK: hold ack_valid until ack_valid&ack_ready at a clock edge, then IDLE.
- A header byte received mid-frame is treated as data. There is no resync except by timeout.
- Timeout: the counter clears on every rx_done and counts only in ADDR/DATA/CHK. When it reaches TIMEOUT_CYCLES-1, the parser goes to IDLE with no ack and err_count increments.
- EXEC decode, in priority order:
  - checksum mismatch → NAK 8'h15.
  - unknown addr → NAK 8'h15.
  - addr 0x02 with D0[1:0]==2'b11 → NAK 8'h15.
  - addr 0x01/0x02/0x03 while run==1 → NAK 8'h16 (busy).
  - otherwise apply the write and ACK 8'h06.
- Register map:
  - 0x01: timing_window=D0.
  - 0x02: test_mode=D0[1:0].
  - 0x03: chan_enable={D3,D2,D1,D0}[CHAN_NUM-1:0], little-endian, D0 bit0 = channel 0.
  - 0x04: run=D0[0]; if D0[1], soft_rst pulses for one cycle. Always accepted.
- Latency: CHK rx_done sampled at edge k puts the FSM in EXEC. At edge k+1 the config outputs, soft_rst, ack_data/ack_valid and err_count all update together. soft_rst deasserts at edge k+2.
- rx_done strobes arriving in EXEC/ACK are discarded and not counted.
- err_count saturates at 8'hFF and increments once per NAK or timeout.
- Reset asserted mid-frame or mid-ACK returns all state and outputs to reset values immediately.

Decomposition:
- Package host_cmd_pkg holds:
  - state enum: IDLE, ADDR, DATA, CHK, EXEC, ACK
  - address constants: ADDR_TW=8'h01, ADDR_MODE=8'h02, ADDR_CHEN=8'h03, ADDR_CTRL=8'h04
  - response codes: RSP_ACK=8'h06, RSP_NAK=8'h15, RSP_BUSY=8'h16
- One natural sub-module, host_cmd_frame_rx: header detect, byte assembly, checksum, timeout. It outputs frame_valid, chk_ok, addr and data[31:0]. The top level does register execution, busy check and the ACK handshake.

Test Plan:
- Reset then A5 01 14 00 00 00 15, ack_ready=1 → timing_window=8'd20 two cycles after CHK strobe, ack_data=06 with one-cycle ack_valid, err_count=0.
- A5 03 FF FF 00 00 03 → chan_enable=32'h0000FFFF, ACK 06. Then A5 02 03 00 00 00 01 → NAK 15, test_mode stays 00, err_count=1.
- A5 04 01 00 00 00 05 → run=1, ACK. Then A5 01 30 00 00 00 31 → NAK 16, timing_window unchanged. Then A5 04 02 00 00 00 06 → run=0, soft_rst high for exactly one cycle.
- A5 01 14 00 00 00 99 (bad CHK) → NAK 15, timing_window unchanged, err_count increments.
- A5 01, then idle for TIMEOUT_CYCLES → no ack_valid, err_count+1. The next valid frame is accepted normally.
- Hold ack_ready=0 for 50 cycles after a valid frame while injecting rx_done bytes → ack_valid and ack_data stable, injected bytes ignored. ack_ready=1 → single handshake, then IDLE. Assert rst_n low mid-frame → all outputs return to reset values.
